// File: rtl/polar_clip_mul_stream_ctrl_if.sv
// AXI-Stream style bundle (data, valid, last, ready) shared by the input and output
// sides of the multiplier stream controller.
interface polar_clip_mul_stream_ctrl_if #(
  parameter int W = 16
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/polar_clip_mul_stream_ctrl.sv
// Stream wrapper around an external pipelined 16x16 signed multiplier: credit-based
// admission, valid/last tracking alongside the pipeline and a FWFT result FIFO.
module polar_clip_mul_stream_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int DATA_W      = 16
) (
  input  logic                ap_clk,
  input  logic                ap_rst_n,
  polar_clip_mul_stream_ctrl_if.slave  s_axis,
  polar_clip_mul_stream_ctrl_if.master m_axis,
  output logic                mul_ce,
  output logic [DATA_W-1:0]   mul_din0,
  output logic [DATA_W-1:0]   mul_din1,
  input  logic [DATA_W-1:0]   mul_dout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int AW    = PTR_W + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic                   mul_ce_q, mul_ce_d;
  logic [DATA_W-1:0]      din0_q, din0_d;
  logic [DATA_W-1:0]      din1_q, din1_d;
  logic [MUL_LATENCY-1:0] vld_q, vld_d;
  logic [MUL_LATENCY-1:0] last_q, last_d;
  logic [OCC_W-1:0]       occ_q, occ_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;

  logic [DATA_W:0]        fifo_mem [FIFO_DEPTH];
  logic [DATA_W:0]        fifo_head;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   wr_en;
  logic                   rd_en;
  logic                   in_hs;
  logic                   s_tready;

  // Occupancy counts in-flight products plus buffered results, so a free credit
  // always implies a free FIFO slot by the time the product emerges.
  assign s_tready      = (occ_q < OCC_W'(FIFO_DEPTH)) && mul_ce_q;
  assign s_axis.tready = s_tready;
  assign in_hs         = s_axis.tvalid && s_tready;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign wr_en      = vld_q[MUL_LATENCY-1] && !fifo_full;
  assign rd_en      = !fifo_empty && m_axis.tready;
  assign fifo_head  = fifo_mem[rd_ptr_q[PTR_W-1:0]];

  assign m_axis.tvalid = !fifo_empty;
  assign m_axis.tdata  = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign m_axis.tlast  = !fifo_empty && fifo_head[DATA_W];

  assign mul_ce   = mul_ce_q;
  assign mul_din0 = din0_q;
  assign mul_din1 = din1_q;

  always_comb begin
    mul_ce_d = 1'b1;
    din0_d   = din0_q;
    din1_d   = din1_q;
    if (in_hs) begin
      din0_d = s_axis.tdata[DATA_W-1:0];
      din1_d = s_axis.tdata[2*DATA_W-1:DATA_W];
    end
  end

  always_comb begin
    vld_d     = '0;
    last_d    = '0;
    vld_d[0]  = in_hs;
    last_d[0] = in_hs && s_axis.tlast;
    for (int i = 1; i < MUL_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      last_d[i] = last_q[i-1];
    end
  end

  always_comb begin
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    case ({in_hs, rd_en})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      mul_ce_q <= 1'b0;
      din0_q   <= '0;
      din1_q   <= '0;
      vld_q    <= '0;
      last_q   <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mul_ce_q <= mul_ce_d;
      din0_q   <= din0_d;
      din1_q   <= din1_d;
      vld_q    <= vld_d;
      last_q   <= last_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge ap_clk) begin
    if (wr_en) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {last_q[MUL_LATENCY-1], mul_dout};
  end

endmodule

// File: tb/tb_polar_clip_mul_stream_ctrl.sv
// Bench for polar_clip_mul_stream_ctrl: behavioural 4-cycle multiplier, scoreboard queue
// filled on input handshakes and drained on output handshakes.
module tb_polar_clip_mul_stream_ctrl;
  localparam int DW = 16;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  polar_clip_mul_stream_ctrl_if #(.W(2*DW)) s_if ();
  polar_clip_mul_stream_ctrl_if #(.W(DW))   m_if ();

  logic          mul_ce;
  logic [DW-1:0] mul_din0, mul_din1, mul_dout;

  polar_clip_mul_stream_ctrl #(.MUL_LATENCY(4), .FIFO_DEPTH(8), .DATA_W(DW)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .s_axis   (s_if),
    .m_axis   (m_if),
    .mul_ce   (mul_ce),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout)
  );

  // Multiplier stand-in: operands registered in the DUT, three more stages here.
  logic signed [2*DW-1:0] mul_full;
  logic [DW-1:0] mul_s1, mul_s2, mul_s3;
  assign mul_full = $signed(mul_din0) * $signed(mul_din1);
  always @(posedge ap_clk) begin
    if (mul_ce) begin
      mul_s1 <= mul_full[DW-1:0];
      mul_s2 <= mul_s1;
      mul_s3 <= mul_s2;
    end
  end
  assign mul_dout = mul_s3;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_push = 0;
  int n_pop = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int rdy_mode = 1;
  logic [DW:0] exp_q[$];
  logic [DW:0] last_pop = '0;
  logic [DW:0] mon_e;
  logic [DW:0] hold_val = '0;
  bit hold_pending = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model_prod(input logic [2*DW-1:0] d);
    logic signed [2*DW-1:0] p;
    p = $signed(d[DW-1:0]) * $signed(d[2*DW-1:DW]);
    return p[DW-1:0];
  endfunction

  always @(posedge ap_clk) cyc++;

  always @(posedge ap_clk) begin
    #1;
    case (rdy_mode)
      0:       m_if.tready = 1'b1;
      1:       m_if.tready = 1'b0;
      default: m_if.tready = 1'($urandom_range(1));
    endcase
  end

  // Monitor samples mid-cycle; each observed handshake completes on the next rising edge.
  always @(negedge ap_clk) begin
    if (ap_rst_n) begin
      if (s_if.tvalid && s_if.tready) begin
        exp_q.push_back({s_if.tlast, model_prod(s_if.tdata)});
        n_push++;
      end
      if (hold_pending) begin
        check_eq("hold_valid", 32'(m_if.tvalid), 32'd1);
        check_eq("hold_data", 32'({m_if.tlast, m_if.tdata}), 32'(hold_val));
      end
      hold_pending = m_if.tvalid && !m_if.tready;
      hold_val = {m_if.tlast, m_if.tdata};
      if (m_if.tvalid && m_if.tready) begin
        if (exp_q.size() == 0) begin
          check_eq("out_unexpected", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("out_data", 32'(m_if.tdata), 32'(mon_e[DW-1:0]));
          check_eq("out_last", 32'(m_if.tlast), 32'(mon_e[DW]));
        end
        n_pop++;
        last_pop = {m_if.tlast, m_if.tdata};
        if (n_pop == 1) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (dut.vld_q[3]) check_eq("full_on_write", 32'(dut.fifo_full), 32'd0);
    end else begin
      hold_pending = 0;
    end
  end

  task automatic send(input logic [31:0] d, input logic l, output int waits, output int hs_cyc);
    s_if.tdata = d;
    s_if.tlast = l;
    s_if.tvalid = 1'b1;
    waits = 0;
    hs_cyc = 0;
    while (1) begin
      @(negedge ap_clk);
      if (s_if.tready) begin
        hs_cyc = cyc + 1;
        break;
      end
      waits++;
      if (waits > 200) begin
        check_eq("send_timeout", 32'(waits), 32'd0);
        break;
      end
    end
    @(posedge ap_clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge ap_clk);
      n++;
    end
    @(posedge ap_clk);
    #1;
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout cycle=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w, hs, lat, cnt;
    logic [31:0] t2_in[3];
    logic [15:0] t2_exp[3];
    t2_in[0] = 32'h0002_FFFF; t2_exp[0] = 16'hFFFE;
    t2_in[1] = 32'h0100_0100; t2_exp[1] = 16'h0000;
    t2_in[2] = 32'h8000_FFFF; t2_exp[2] = 16'h8000;

    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tlast = 1'b0;
    m_if.tready = 1'b0;

    // Reset state
    repeat (3) @(posedge ap_clk);
    #1;
    check_eq("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    check_eq("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    check_eq("rst_s_tready", 32'(s_if.tready), 32'd0);
    check_eq("rst_mul_ce", 32'(mul_ce), 32'd0);
    check_eq("rst_din0", 32'(mul_din0), 32'd0);
    check_eq("rst_din1", 32'(mul_din1), 32'd0);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
    check_eq("rel_mul_ce_pre", 32'(mul_ce), 32'd0);
    @(posedge ap_clk);
    #1;
    check_eq("rel_mul_ce", 32'(mul_ce), 32'd1);
    check_eq("rel_s_tready", 32'(s_if.tready), 32'd1);
    rdy_mode = 0;
    @(posedge ap_clk);
    #2;

    // 1: single word, latency
    send(32'h0005_0003, 1'b1, w, hs);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (m_if.tvalid) begin
        lat = cyc - hs;
        break;
      end
    end
    check_eq("t1_latency", 32'(lat), 32'd4);
    drain("t1_drain");
    check_eq("t1_result", 32'(last_pop), 32'h1000F);

    // 2: sign and wrap corner cases
    for (int i = 0; i < 3; i++) begin
      send(t2_in[i], 1'b0, w, hs);
      drain("t2_drain");
      check_eq("t2_result", 32'(last_pop), 32'(t2_exp[i]));
    end

    // 3: back-to-back stream with free-running sink
    n_pop = 0;
    for (int i = 0; i < 32; i++) begin
      send($urandom, 1'(i == 31), w, hs);
      check_eq("t3_tready_drop", 32'(w), 32'd0);
    end
    drain("t3_drain");
    check_eq("t3_count", 32'(n_pop), 32'd32);
    check_eq("t3_rate", 32'(last_pop_cyc - first_pop_cyc), 32'd31);

    // 4: blocked sink, credits run out at FIFO depth
    rdy_mode = 1;
    @(posedge ap_clk);
    #2;
    n_push = 0;
    n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      send(32'h0003_0010 + 32'(i), 1'(i == 7), w, hs);
      check_eq("t4_accept_stall", 32'(w), 32'd0);
    end
    s_if.tdata = 32'h0009_0009;
    s_if.tvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (s_if.tready) cnt++;
    end
    check_eq("t4_tready_low", 32'(cnt), 32'd0);
    check_eq("t4_accepted", 32'(n_push), 32'd8);
    s_if.tvalid = 1'b0;
    rdy_mode = 0;
    drain("t4_drain");
    check_eq("t4_popped", 32'(n_pop), 32'd8);

    // 5: random valid/ready, tlast every 7th
    rdy_mode = 2;
    n_pop = 0;
    for (int i = 0; i < 1000; i++) begin
      while ($urandom_range(1) == 0) begin
        @(posedge ap_clk);
        #1;
      end
      send($urandom, 1'((i % 7) == 6), w, hs);
    end
    rdy_mode = 0;
    drain("t5_drain");
    check_eq("t5_count", 32'(n_pop), 32'd1000);

    // 6: reset with 5 buffered and 3 in flight
    rdy_mode = 1;
    @(posedge ap_clk);
    #2;
    for (int i = 0; i < 5; i++) send(32'h1234_0101 + 32'(i), 1'b0, w, hs);
    repeat (6) @(posedge ap_clk);
    #1;
    for (int i = 0; i < 3; i++) send(32'h0777_0303 + 32'(i), 1'(i == 2), w, hs);
    ap_rst_n = 1'b0;
    #1;
    check_eq("t6_m_tvalid", 32'(m_if.tvalid), 32'd0);
    check_eq("t6_m_tdata", 32'(m_if.tdata), 32'd0);
    check_eq("t6_m_tlast", 32'(m_if.tlast), 32'd0);
    check_eq("t6_s_tready", 32'(s_if.tready), 32'd0);
    check_eq("t6_mul_ce", 32'(mul_ce), 32'd0);
    check_eq("t6_din0", 32'(mul_din0), 32'd0);
    check_eq("t6_din1", 32'(mul_din1), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    rdy_mode = 0;
    #1;
    check_eq("t6_ce_pre", 32'(mul_ce), 32'd0);
    @(posedge ap_clk);
    #1;
    check_eq("t6_ce_post", 32'(mul_ce), 32'd1);
    n_pop = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      if (m_if.tvalid) cnt++;
    end
    check_eq("t6_quiet", 32'(cnt), 32'd0);
    check_eq("t6_no_pop", 32'(n_pop), 32'd0);
    @(posedge ap_clk);
    #1;
    send(32'h0007_0006, 1'b1, w, hs);
    drain("t6_drain");
    check_eq("t6_result", 32'(last_pop), 32'h1002A);
    check_eq("t6_count", 32'(n_pop), 32'd1);

    check_eq("final_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
